// File: rtl/dvd_motion_scheduler.sv
// Frame-rate motion scheduler for the bouncing-pixel screensaver.
// Steps every object's x then y through one shared bounce unit.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   vsync             frame sync, same clock domain, active high
//   speed_div         step once every speed_div+1 frames
//   pause             freeze divider and positions between frames
//   init_dir          per-object {dir_x,dir_y}, loaded during reset
//   pos_x, pos_y      packed object positions, object k at slot k
//   busy              update sequence running
//   frame_tick        pulse in the first cycle of a sequence
//   bounce, corner    reflect pulses, one cycle after UPD_Y(k)
module dvd_motion_scheduler #(
  parameter int NUM_OBJ = 2,
  parameter int X_MAX   = 19,
  parameter int Y_MAX   = 14,
  parameter int XW      = 5,
  parameter int YW      = 4,
  parameter int DIVW    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vsync,
  input  logic [DIVW-1:0]         speed_div,
  input  logic                    pause,
  input  logic [2*NUM_OBJ-1:0]    init_dir,
  output logic [NUM_OBJ*XW-1:0]   pos_x,
  output logic [NUM_OBJ*YW-1:0]   pos_y,
  output logic                    busy,
  output logic                    frame_tick,
  output logic [NUM_OBJ-1:0]      bounce,
  output logic                    corner
);

  localparam int IW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int PW = (XW > YW) ? XW : YW;
  localparam logic [PW-1:0] XM = PW'(X_MAX);
  localparam logic [PW-1:0] YM = PW'(Y_MAX);
  localparam logic [IW-1:0] LAST = IW'(NUM_OBJ - 1);

  typedef enum logic [1:0] {
    IDLE,
    UPD_X,
    UPD_Y,
    DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      vs_prev_q, vs_prev_d;
  logic [DIVW-1:0]           frame_cnt_q, frame_cnt_d;
  logic                      pending_q, pending_d;
  logic [NUM_OBJ-1:0][XW-1:0] x_q, x_d;
  logic [NUM_OBJ-1:0][YW-1:0] y_q, y_d;
  logic [NUM_OBJ-1:0]        dx_q, dx_d;
  logic [NUM_OBJ-1:0]        dy_q, dy_d;
  logic                      rx_q, rx_d;
  logic                      frame_tick_q, frame_tick_d;
  logic [NUM_OBJ-1:0]        bounce_q, bounce_d;
  logic                      corner_q, corner_d;

  logic          vs_edge;
  logic          req;
  logic          on_y;
  logic          s_dir;
  logic          s_refl;
  logic [PW-1:0] s_pos;
  logic [PW-1:0] s_max;
  logic [PW-1:0] s_next;

  function automatic logic [XW-1:0] rst_x(input int k);
    int v;
    v = 4 * k;
    if (v > X_MAX) v = X_MAX;
    return XW'(v);
  endfunction

  function automatic logic [YW-1:0] rst_y(input int k);
    int v;
    v = 1 + 3 * k;
    if (v > Y_MAX) v = Y_MAX;
    return YW'(v);
  endfunction

  // Shared step unit: axis picked by state, object by idx_q.
  always_comb begin
    on_y   = (state_q == UPD_Y);
    s_pos  = on_y ? PW'(y_q[idx_q]) : PW'(x_q[idx_q]);
    s_max  = on_y ? YM : XM;
    s_dir  = on_y ? dy_q[idx_q] : dx_q[idx_q];
    s_refl = s_dir ? (s_pos == s_max) : (s_pos == '0);
    if (s_refl) begin
      s_next = s_pos;
    end else if (s_dir) begin
      s_next = s_pos + 1'b1;
    end else begin
      s_next = s_pos - 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    vs_prev_d    = vsync;
    frame_cnt_d  = frame_cnt_q;
    pending_d    = pending_q;
    x_d          = x_q;
    y_d          = y_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    rx_d         = rx_q;
    frame_tick_d = 1'b0;
    bounce_d     = '0;
    corner_d     = 1'b0;
    req          = 1'b0;

    vs_edge = vsync & ~vs_prev_q;
    if (vs_edge && !pause) begin
      if (frame_cnt_q >= speed_div) begin
        frame_cnt_d = '0;
        req         = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d      = UPD_X;
          idx_d        = '0;
          frame_tick_d = 1'b1;
        end
      end
      UPD_X: begin
        x_d[idx_q]  = XW'(s_next);
        dx_d[idx_q] = s_dir ^ s_refl;
        rx_d        = s_refl;
        state_d     = UPD_Y;
        if (req) pending_d = 1'b1;
      end
      UPD_Y: begin
        y_d[idx_q]      = YW'(s_next);
        dy_d[idx_q]     = s_dir ^ s_refl;
        bounce_d[idx_q] = rx_q | s_refl;
        corner_d        = rx_q & s_refl;
        if (req) pending_d = 1'b1;
        if (idx_q == LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = UPD_X;
        end
      end
      DONE: begin
        // A request queued during the run restarts immediately.
        if (pending_q || req) begin
          pending_d    = 1'b0;
          state_d      = UPD_X;
          idx_d        = '0;
          frame_tick_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      vs_prev_q    <= 1'b0;
      frame_cnt_q  <= '0;
      pending_q    <= 1'b0;
      rx_q         <= 1'b0;
      frame_tick_q <= 1'b0;
      bounce_q     <= '0;
      corner_q     <= 1'b0;
      for (int k = 0; k < NUM_OBJ; k++) begin
        x_q[k]  <= rst_x(k);
        y_q[k]  <= rst_y(k);
        dx_q[k] <= init_dir[2*k+1];
        dy_q[k] <= init_dir[2*k];
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      vs_prev_q    <= vs_prev_d;
      frame_cnt_q  <= frame_cnt_d;
      pending_q    <= pending_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      rx_q         <= rx_d;
      frame_tick_q <= frame_tick_d;
      bounce_q     <= bounce_d;
      corner_q     <= corner_d;
    end
  end

  assign pos_x      = x_q;
  assign pos_y      = y_q;
  assign busy       = (state_q != IDLE);
  assign frame_tick = frame_tick_q;
  assign bounce     = bounce_q;
  assign corner     = corner_q;

endmodule
